// File: rtl/vedic_seq_mac.sv
// rtl/vedic_seq_mac.sv - multi-cycle unsigned multiply-accumulate built on a time-multiplexed 2x2 Vedic core
module vedic_seq_mac #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [ACC_W-1:0]     acc,
   output logic                 acc_ovf
);

   localparam int N  = WIDTH / 2;
   localparam int DW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DW-1:0] LAST_DIGIT = DW'(N - 1);

   // 2x2 Vedic (urdhva-tiryagbhyam) digit product: vertical, crosswise, vertical
   function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
      logic p0, t1, t2, hi, c1;
      p0 = x[0] & y[0];
      t1 = x[1] & y[0];
      t2 = x[0] & y[1];
      hi = x[1] & y[1];
      c1 = t1 & t2;
      return {hi & c1, hi ^ c1, t1 ^ t2, p0};
   endfunction

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               clr_q;
   // i walks the a digits (inner loop), j walks the b digits (outer loop)
   logic [DW-1:0]      i_cnt;
   logic [DW-1:0]      j_cnt;

   logic [1:0]         a_dig;
   logic [1:0]         b_dig;
   logic [3:0]         pp;
   logic [2*WIDTH-1:0] pp_ext;
   logic [2*WIDTH-1:0] pp_shift;
   logic [2*WIDTH-1:0] prod_next;
   logic [ACC_W-1:0]   acc_base;
   logic [ACC_W:0]     prod_wide;
   logic [ACC_W:0]     acc_sum;
   logic               last_step;
   int                 shamt;

   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);
   assign last_step = (i_cnt == LAST_DIGIT) && (j_cnt == LAST_DIGIT);

   // Current digit pair, its weighted partial product and the accumulator update it would produce
   always_comb begin
      a_dig     = a_q[2*int'(i_cnt) +: 2];
      b_dig     = b_q[2*int'(j_cnt) +: 2];
      pp        = vedic_2x2(a_dig, b_dig);
      pp_ext    = '0;
      pp_ext[3:0] = pp;
      shamt     = 2 * (int'(i_cnt) + int'(j_cnt));
      pp_shift  = pp_ext << shamt;
      prod_next = product + pp_shift;
      acc_base  = clr_q ? '0 : acc;
      prod_wide = '0;
      prod_wide[2*WIDTH-1:0] = prod_next;
      acc_sum   = {1'b0, acc_base} + prod_wide;
   end

   // Control FSM, digit counters and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         clr_q   <= 1'b0;
         i_cnt   <= '0;
         j_cnt   <= '0;
         product <= '0;
         acc     <= '0;
         acc_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  clr_q   <= acc_clr;
                  i_cnt   <= '0;
                  j_cnt   <= '0;
                  product <= '0;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               product <= prod_next;
               if (last_step) begin
                  acc     <= acc_sum[ACC_W-1:0];
                  acc_ovf <= (clr_q ? 1'b0 : acc_ovf) | acc_sum[ACC_W];
                  i_cnt   <= '0;
                  j_cnt   <= '0;
                  state   <= S_DONE;
               end else if (i_cnt == LAST_DIGIT) begin
                  i_cnt <= '0;
                  j_cnt <= j_cnt + 1'b1;
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
